alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- TinyTapeout top-level front end for the 8-bit ALU. It feeds operand A, operand B and the 2-bit opcode into alu_8bits over three strobed transfers on the shared ui_in bus.
- It registers the ALU result on uo_out and reports progress and completion status on uio_out.
- Together with alu_8bits it replaces the single-cycle wrapper that tried to drive a, b and S from the same pins at once.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the strobe/clear synchronisers; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; when low, the FSM and all capture registers hold.
- ui_in  in  8  data bus: operand A, operand B, or opcode in ui_in[1:0], depending on phase.
- uio_in  in  8  [0] strb, load strobe (async pin). [1] clr, sequence clear (async pin). [7:2] ignored.
- uo_out  out  8  registered ALU result.
- uio_out  out  8  [7] busy, [6] done, [5:4] phase, [3:0] = 0.
- uio_oe  out  8  constant 8'hF0.

Behaviour:
- Reset: clk and rst_n are the only clock and reset; reset is async active-low. On reset, A_q, B_q, op_q and result_q all = 0. State = WAIT_A, done = 0, busy = 0, phase = 0, synchronisers = 0.
- Synchronisers: strb and clr each pass through SYNC_STAGES flops.
- Strobe edge: strb_rise = last sync stage & ~previous value of that stage. Only a rising edge counts; holding strb high yields one event.
- Strobe latency (SYNC_STAGES = 2): strb first sampled high at edge N gives capture at edge N+2. Data on ui_in must be stable from edge N through edge N+2.
- States (phase encoding):
  - WAIT_A (0): on strb_rise, A_q <= ui_in, done <= 0, go to WAIT_B.
  - WAIT_B (1): on strb_rise, B_q <= ui_in, go to WAIT_OP.
  - WAIT_OP (2): on strb_rise, op_q <= ui_in[1:0], go to EXEC. ui_in[7:2] are ignored.
  - EXEC (3): unconditional single cycle. result_q <= alu_8bits.Result(A_q, B_q, op_q), done <= 1, go to WAIT_A.
- Result latency: result_q updates exactly one edge after the opcode capture. uo_out = result_q always, and holds its value until the next EXEC.
- busy = (state != WAIT_A). done stays high from EXEC until the next A capture, clr, or reset.
- A strb_rise during EXEC is dropped; it is not queued.
- clr (synchronised level): while high, state <= WAIT_A and done <= 0. A_q, B_q, op_q and result_q are retained. clr beats a simultaneous strb_rise.
- ena low: state, captures and done freeze; strobe edges arriving while ena is low are lost. The synchronisers keep running, so a strobe already held high when ena rises does not fire.
- Mid-sequence reset: an asynchronous return to the full reset state, including result_q = 0.
- Arithmetic width, wrap-around and op semantics come from alu_8bits (8-bit result, modulo 256). The sequencer adds no extra width.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11;
  - the state/phase encoding constants;
  - UIO_OE_MASK = 8'hF0.
- One natural sub-module: sync_edge (synchroniser plus rising-edge detect, parameter SYNC_STAGES), instantiated once for strb and once for clr (clr uses only the level output).
- alu_8bits is instantiated unchanged.

Test Plan:
- Reset: assert rst_n = 0 mid-sequence -> uo_out = 0, uio_out = 8'h00, uio_oe = 8'hF0 immediately (asynchronously).
- Basic ADD: strobe A = 8'h25, B = 8'h13, op = 2'b00 -> uo_out = 8'h38. done rises exactly 1 clk after op capture; phase steps 0,1,2,3,0.
- Wrap: A = 8'hF0, B = 8'h20, op = ADD -> uo_out = 8'h10. SUB with A = 8'h05, B = 8'h07 -> uo_out = 8'hFE.
- Strobe discipline: hold strb high for 10 clks during WAIT_A -> only A is captured (phase = 1). Then pulse strb 1 clk wide -> B is captured 2 clks later.
- clr: after A and B are captured, raise clr together with strb -> phase = 0, done = 0, previous uo_out is unchanged, and no opcode is captured.
- ena gating: ena = 0 during a full strobe pulse in WAIT_B -> phase stays 1. After ena = 1 and a new strobe -> B is captured.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, phase and pad constants for the ALU front end.
// Imported by the sequencer and the ALU core.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        EXEC    = 2'd3
    } phase_e;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/alu_8bits.sv
// Combinational 8-bit ALU: add, sub, and, or.
// Result wraps modulo 256.
import alu_pkg::*;

module alu_8bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] S,
    output logic [7:0] Result
);

    // Select the operation named by the opcode
    always_comb begin
        Result = 8'h00;
        unique case (S)
            OP_ADD:  Result = a + b;
            OP_SUB:  Result = a - b;
            OP_AND:  Result = a & b;
            OP_OR:   Result = a | b;
            default: Result = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_operand_sequencer_sync_edge.sv
// Multi-flop synchroniser with rising-edge detect.
// The edge flop runs free so a held level fires once.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], d_i};
    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;

    // Shift the pin through the chain and remember the last stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= level_o;
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// TinyTapeout front end: strobes A, B and opcode in over ui_in,
// runs alu_8bits once and holds the result on uo_out.
import alu_pkg::*;

module alu_operand_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    phase_e     state_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [1:0] op_q;
    logic [7:0] result_q;
    logic       done_q;

    logic       strb_rise;
    logic       strb_lvl;
    logic       clr_lvl;
    logic       clr_rise;
    logic [7:0] alu_res;
    logic       unused_ok;

    assign unused_ok = ^{uio_in[7:2], strb_lvl, clr_rise};

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_strb (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (uio_in[0]),
        .level_o (strb_lvl),
        .rise_o  (strb_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (uio_in[1]),
        .level_o (clr_lvl),
        .rise_o  (clr_rise)
    );

    alu_8bits u_alu (
        .a      (a_q),
        .b      (b_q),
        .S      (op_q),
        .Result (alu_res)
    );

    // Phase sequencer: clr wins over any strobe, ena freezes all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_A;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= 2'b00;
            result_q <= 8'h00;
            done_q   <= 1'b0;
        end else if (ena) begin
            if (clr_lvl) begin
                state_q <= WAIT_A;
                done_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    WAIT_A: if (strb_rise) begin
                        a_q     <= ui_in;
                        done_q  <= 1'b0;
                        state_q <= WAIT_B;
                    end
                    WAIT_B: if (strb_rise) begin
                        b_q     <= ui_in;
                        state_q <= WAIT_OP;
                    end
                    WAIT_OP: if (strb_rise) begin
                        op_q    <= ui_in[1:0];
                        state_q <= EXEC;
                    end
                    EXEC: begin
                        result_q <= alu_res;
                        done_q   <= 1'b1;
                        state_q  <= WAIT_A;
                    end
                    default: state_q <= WAIT_A;
                endcase
            end
        end
    end

    assign uo_out  = result_q;
    assign uio_out = {(state_q != WAIT_A), done_q, state_q, 4'h0};
    assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: table vectors,
// hand-written corner sequences and a randomized model run.
module tb_alu_operand_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic       strb;
    logic       clr;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors;
    int miscompares;
    logic [7:0] last_exp;

    assign uio_in = {6'd0, clr, strb};

    alu_operand_sequencer #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[6];

    // Reference arithmetic from the opcode definitions
    function automatic logic [7:0] ref_alu(input int a, input int b, input int op);
        int r;
        case (op)
            0: r = (a + b) % 256;
            1: r = (a - b + 256) % 256;
            2: r = a & b;
            default: r = a | b;
        endcase
        return r[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk_phase(input string name, input int ph, input bit dn);
        logic [7:0] e;
        e = {(ph != 0), dn, 6'd0};
        e[5:4] = ph[1:0];
        check(name, uio_out, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise strb with data, hold 3 edges, release and let the sync drain
    task automatic pulse(input logic [7:0] d);
        ui_in = d;
        strb  = 1'b1;
        tick(3);
        strb  = 1'b0;
        tick(3);
    endtask

    // Opcode strobe with exact-latency checks of EXEC and done
    task automatic op_strobe(input logic [1:0] op, input logic [7:0] exp, input logic [7:0] prev);
        logic [7:0] junk;
        junk  = 8'($urandom);
        ui_in = {junk[7:2], op};
        strb  = 1'b1;
        tick(2);
        chk_phase("pre_op_phase", 2, 1'b0);
        tick(1);
        chk_phase("exec_phase", 3, 1'b0);
        check("exec_uo_hold", uo_out, prev);
        tick(1);
        chk_phase("done_phase", 0, 1'b1);
        check("result", uo_out, exp);
        strb = 1'b0;
        tick(3);
    endtask

    task automatic do_seq(input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic [7:0] exp);
        pulse(a);
        chk_phase("after_a", 1, 1'b0);
        pulse(b);
        chk_phase("after_b", 2, 1'b0);
        op_strobe(op, exp, last_exp);
        last_exp = exp;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_exp    = 8'h00;
        rst_n = 1'b0;
        ena   = 1'b1;
        ui_in = 8'h00;
        strb  = 1'b0;
        clr   = 1'b0;

        tbl[0] = '{8'h25, 8'h13, 2'b00, 8'h38};
        tbl[1] = '{8'hF0, 8'h20, 2'b00, 8'h10};
        tbl[2] = '{8'h05, 8'h07, 2'b01, 8'hFE};
        tbl[3] = '{8'hF0, 8'h3C, 2'b10, 8'h30};
        tbl[4] = '{8'h0F, 8'hA0, 2'b11, 8'hAF};
        tbl[5] = '{8'h80, 8'h01, 2'b01, 8'h7F};

        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("rst_uo", uo_out, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'hF0);

        for (int i = 0; i < 6; i++)
            do_seq(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);

        // Held strobe yields one capture; 1-clk pulse captures 2 clks later
        ui_in = 8'h11;
        strb  = 1'b1;
        tick(10);
        chk_phase("held_strb", 1, 1'b0);
        strb = 1'b0;
        tick(3);
        ui_in = 8'h22;
        strb  = 1'b1;
        tick(1);
        strb  = 1'b0;
        chk_phase("short_n", 1, 1'b0);
        tick(1);
        chk_phase("short_n1", 1, 1'b0);
        tick(1);
        chk_phase("short_n2", 2, 1'b0);
        tick(3);
        op_strobe(2'b00, 8'h33, last_exp);
        last_exp = 8'h33;

        // clr together with strb in WAIT_OP: clr wins
        pulse(8'h40);
        pulse(8'h02);
        ui_in = 8'h01;
        clr   = 1'b1;
        strb  = 1'b1;
        tick(4);
        chk_phase("clr_phase", 0, 1'b0);
        check("clr_uo", uo_out, last_exp);
        clr  = 1'b0;
        strb = 1'b0;
        tick(4);
        chk_phase("clr_idle", 0, 1'b0);

        // ena gating in WAIT_B
        pulse(8'h09);
        ena = 1'b0;
        pulse(8'hFF);
        ena = 1'b1;
        tick(2);
        chk_phase("ena_hold", 1, 1'b0);
        ena   = 1'b0;
        ui_in = 8'hEE;
        strb  = 1'b1;
        tick(4);
        ena = 1'b1;
        tick(4);
        chk_phase("ena_level_held", 1, 1'b0);
        strb = 1'b0;
        tick(3);
        pulse(8'h04);
        chk_phase("ena_b_cap", 2, 1'b0);
        op_strobe(2'b01, 8'h05, last_exp);
        last_exp = 8'h05;

        // Randomized sequences with occasional clr aborts
        for (int i = 0; i < 25; i++) begin
            logic [7:0] ra, rb;
            logic [1:0] rop;
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                pulse(ra);
                pulse(rb);
                clr = 1'b1;
                tick(4);
                chk_phase("rnd_clr", 0, 1'b0);
                check("rnd_clr_uo", uo_out, last_exp);
                clr = 1'b0;
                tick(4);
            end
            do_seq(ra, rb, rop, ref_alu(int'(ra), int'(rb), int'(rop)));
        end

        // Asynchronous reset in the middle of a sequence
        pulse(8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_uo", uo_out, 8'h00);
        check("midrst_uio_out", uio_out, 8'h00);
        check("midrst_uio_oe", uio_oe, 8'hF0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        last_exp = 8'h00;
        do_seq(8'hC3, 8'h3C, 2'b11, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
